// File: rtl/tile_stream_mem.sv
// Tile-addressed single-port memory with ROWSxCOLS burst writes and
// flow-controlled burst reads; out-of-range tile commands are rejected with err.
module tile_stream_mem #(
  parameter int DW    = 32,
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int ROWS  = 4,
  parameter int COLS  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_stride,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          done,
  output logic          err
);

  localparam int NB = ROWS * COLS;
  localparam int BW = $clog2(NB + 1);
  localparam int RW = $clog2(ROWS + 1);
  localparam int CW = $clog2(COLS + 1);
  localparam int EW = AW + 4 + RW + CW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Address of element (ROWS-1, COLS-1), widened so large strides cannot wrap.
  function automatic logic [EW-1:0] tile_last_addr(input logic [AW-1:0] base,
                                                   input logic [AW-1:0] stride);
    return EW'(base) + EW'(ROWS - 1) * EW'(stride) + EW'(COLS - 1);
  endfunction

  state_t        state_r;
  state_t        state_nx;
  logic          cmd_ready_r;
  logic          wr_ready_r;
  logic          rd_valid_r;
  logic          rd_last_r;
  logic [DW-1:0] rd_data_r;
  logic          done_r;
  logic          err_r;
  logic [AW-1:0] stride_r;
  logic [AW-1:0] row_base_r;
  logic [CW-1:0] col_r;
  logic [BW-1:0] beat_r;
  logic [DW-1:0] mem_r [DEPTH];

  logic          accept_s;
  logic          in_range_s;
  logic          wr_beat_s;
  logic          rd_issue_s;
  logic          rd_take_s;
  logic          last_beat_s;
  logic          advance_s;
  logic [AW-1:0] cur_addr_s;

  assign accept_s    = cmd_valid && cmd_ready_r;
  assign in_range_s  = tile_last_addr(cmd_addr, cmd_stride) < EW'(DEPTH);
  assign wr_beat_s   = wr_ready_r && wr_valid;
  assign rd_issue_s  = (state_r == READ) && (!rd_valid_r || rd_ready);
  assign rd_take_s   = rd_valid_r && rd_ready;
  assign last_beat_s = (beat_r == BW'(NB - 1));
  assign advance_s   = wr_beat_s || rd_issue_s;
  assign cur_addr_s  = row_base_r + AW'(col_r);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && in_range_s) begin
          state_nx = cmd_write ? WRITE : READ;
        end else begin
          state_nx = IDLE;
        end
      end
      WRITE: begin
        if (wr_beat_s && last_beat_s) begin
          state_nx = IDLE;
        end else begin
          state_nx = WRITE;
        end
      end
      READ: begin
        if (rd_issue_s && last_beat_s) begin
          state_nx = DRAIN;
        end else begin
          state_nx = READ;
        end
      end
      DRAIN: begin
        if (rd_take_s && rd_last_r) begin
          state_nx = IDLE;
        end else begin
          state_nx = DRAIN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Handshake flags, status pulses and element walk; ready flags track the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready_r <= 1'b1;
      wr_ready_r  <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      stride_r    <= '0;
      row_base_r  <= '0;
      col_r       <= '0;
      beat_r      <= '0;
    end else begin
      cmd_ready_r <= (state_nx == IDLE);
      wr_ready_r  <= (state_nx == WRITE);
      err_r       <= accept_s && !in_range_s;
      done_r      <= (wr_beat_s && last_beat_s) ||
                     ((state_r == DRAIN) && rd_take_s && rd_last_r);
      if (accept_s) begin
        stride_r   <= cmd_stride;
        row_base_r <= cmd_addr;
        col_r      <= '0;
        beat_r     <= '0;
      end else if (advance_s) begin
        beat_r <= beat_r + BW'(1);
        if (col_r == CW'(COLS - 1)) begin
          col_r      <= '0;
          row_base_r <= row_base_r + stride_r;
        end else begin
          col_r <= col_r + CW'(1);
        end
      end
    end
  end

  // Read output register: loads on issue, empties on acceptance, holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
      rd_data_r  <= '0;
    end else if (rd_issue_s) begin
      rd_valid_r <= 1'b1;
      rd_last_r  <= last_beat_s;
      rd_data_r  <= mem_r[cur_addr_s];
    end else if (rd_take_s) begin
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
    end
  end

  // Storage array; deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (wr_beat_s) begin
      mem_r[cur_addr_s] <= wr_data;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign wr_ready  = wr_ready_r;
  assign rd_valid  = rd_valid_r;
  assign rd_last   = rd_last_r;
  assign rd_data   = rd_data_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_tile_stream_mem.sv
// Directed bench for tile_stream_mem: write/read bursts, stalls, bounds
// rejection, mid-burst reset and overlapping-stride writes.
module tb_tile_stream_mem;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [7:0]  cmd_stride;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        done;
  logic        err;

  int checks;
  int failures;
  int done_cnt;
  logic [31:0] exp_q [16];

  tile_stream_mem dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_stride(cmd_stride),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic w, input logic [7:0] a, input logic [7:0] s);
    int t;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_stride = s;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic write_beats(input logic [31:0] first, input int gap, input int n);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = first + 32'(i);
      @(negedge clk);
      check("wr_ready_beat", 32'(wr_ready), 32'd1);
      @(posedge clk); #1;
      wr_valid = 1'b0;
      wr_data  = 32'hDEAD_BEEF;
      if (i != n - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check("wr_ready_gap", 32'(wr_ready), 32'd1);
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic write_done_check();
    check("wr_done_pulse", 32'(done), 32'd1);
    check("wr_cmd_ready_back", 32'(cmd_ready), 32'd1);
    check("wr_ready_low", 32'(wr_ready), 32'd0);
    @(posedge clk); #1;
    check("wr_done_clear", 32'(done), 32'd0);
  endtask

  task automatic read_burst(input logic [7:0] a, input logic [7:0] s, input logic toggle);
    int n;
    int cyc;
    logic held;
    logic [31:0] held_d;
    logic held_l;
    n = 0; cyc = 0; held = 1'b0; held_d = 32'd0; held_l = 1'b0;
    send_cmd(1'b0, a, s);
    while (n < 16 && cyc < 200) begin
      rd_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        if (held) begin
          check("rd_hold_data", rd_data, held_d);
          check("rd_hold_last", 32'(rd_last), 32'(held_l));
        end
        if (rd_ready) begin
          check("rd_data", rd_data, exp_q[n]);
          check("rd_last", 32'(rd_last), (n == 15) ? 32'd1 : 32'd0);
          n++;
          held = 1'b0;
        end else begin
          held   = 1'b1;
          held_d = rd_data;
          held_l = rd_last;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    rd_ready = 1'b0;
    check("rd_beat_count", 32'(n), 32'd16);
    check("rd_done_pulse", 32'(done), 32'd1);
    check("rd_cmd_ready_back", 32'(cmd_ready), 32'd1);
    check("rd_valid_low", 32'(rd_valid), 32'd0);
    @(posedge clk); #1;
    check("rd_done_clear", 32'(done), 32'd0);
  endtask

  initial begin
    int d0;
    checks = 0; failures = 0; done_cnt = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'd0; cmd_stride = 8'd0;
    wr_valid = 1'b0; wr_data = 32'd0; rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_last", 32'(rd_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    @(posedge clk); #1;

    // Basic write 1..16 at 0x10 stride 4, then read back.
    d0 = done_cnt;
    send_cmd(1'b1, 8'h10, 8'd4);
    write_beats(32'd1, 0, 16);
    write_done_check();
    check("wr_done_once", 32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < 16; i++) exp_q[i] = 32'(i + 1);
    d0 = done_cnt;
    read_burst(8'h10, 8'd4, 1'b0);
    check("rd_done_once", 32'(done_cnt - d0), 32'd1);

    // Write with 3-cycle gaps at 0x20 stride 8, then read with rd_ready toggling.
    send_cmd(1'b1, 8'h20, 8'd8);
    write_beats(32'hA0, 3, 16);
    write_done_check();
    for (int i = 0; i < 16; i++) exp_q[i] = 32'hA0 + 32'(i);
    read_burst(8'h20, 8'd8, 1'b1);

    // Highest legal tile accepted; one word further rejected.
    send_cmd(1'b1, 8'hF0, 8'd4);
    check("edge_accept_wr_ready", 32'(wr_ready), 32'd1);
    check("edge_accept_err", 32'(err), 32'd0);
    write_beats(32'h200, 0, 16);
    write_done_check();
    send_cmd(1'b1, 8'hF1, 8'd4);
    check("oob_err_pulse", 32'(err), 32'd1);
    check("oob_stays_idle", 32'(cmd_ready), 32'd1);
    check("oob_no_wr_ready", 32'(wr_ready), 32'd0);
    wr_valid = 1'b1; wr_data = 32'hDEAD;
    @(posedge clk); #1;
    check("oob_err_clear", 32'(err), 32'd0);
    check("oob_wr_ready_still_low", 32'(wr_ready), 32'd0);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    for (int i = 0; i < 16; i++) exp_q[i] = 32'h200 + 32'(i);
    read_burst(8'hF0, 8'd4, 1'b0);

    // Reset after 7 of 16 beats over a pre-filled tile at 0x40.
    send_cmd(1'b1, 8'h40, 8'd4);
    write_beats(32'h50, 0, 16);
    write_done_check();
    send_cmd(1'b1, 8'h40, 8'd4);
    write_beats(32'h300, 0, 7);
    rst = 1'b1;
    #1;
    check("midrst_wr_ready", 32'(wr_ready), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_rd_valid", 32'(rd_valid), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) exp_q[i] = (i < 7) ? 32'h300 + 32'(i) : 32'h50 + 32'(i);
    read_burst(8'h40, 8'd4, 1'b0);

    // Overlapping rows: stride 2 over a pre-filled 0..15 region, later beats win.
    send_cmd(1'b1, 8'h00, 8'd4);
    write_beats(32'h400, 0, 16);
    write_done_check();
    send_cmd(1'b1, 8'h00, 8'd2);
    write_beats(32'd1, 0, 16);
    write_done_check();
    exp_q = '{32'd1, 32'd2, 32'd5, 32'd6, 32'd9, 32'd10, 32'd13, 32'd14,
              32'd15, 32'd16, 32'h40A, 32'h40B, 32'h40C, 32'h40D, 32'h40E, 32'h40F};
    read_burst(8'h00, 8'd4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
